// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS multiply/divide unit with committed HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (6-9).
module mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MUL_LAST = WIDTH'(MUL_LAT - 1);
   localparam logic [WIDTH-1:0] DIV_LAST = WIDTH'(WIDTH - 1);

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic               r_divZero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_aHold;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_qNeg;
   logic               r_rNeg;
   logic               r_bZero;
`ifdef MDU_MADD_EN
   logic               r_accAdd;
   logic               r_accSub;
`endif

   logic               w_isMul;
   logic               w_mulSigned;
   logic               w_isDivS;
   logic               w_isDiv;
   logic [2*WIDTH-1:0] w_aExt;
   logic [2*WIDTH-1:0] w_bExt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic [WIDTH:0]     w_trial;
   logic               w_fits;
   logic [WIDTH-1:0]   w_quoFix;
   logic [WIDTH-1:0]   w_remFix;
   logic [2*WIDTH-1:0] w_mulResult;

   // Opcode decode for the multiply family; accumulate ops share MUL timing.
   always_comb begin
      w_isMul     = 1'b0;
      w_mulSigned = 1'b0;
      case (op)
         OP_MULT: begin
            w_isMul     = 1'b1;
            w_mulSigned = 1'b1;
         end
         OP_MULTU: begin
            w_isMul = 1'b1;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MSUB: begin
            w_isMul     = 1'b1;
            w_mulSigned = 1'b1;
         end
         OP_MADDU, OP_MSUBU: begin
            w_isMul = 1'b1;
         end
`endif
         default: begin
            w_isMul     = 1'b0;
            w_mulSigned = 1'b0;
         end
      endcase
   end

   // Full product is formed at acceptance and held until the commit edge.
   always_comb begin
      w_isDivS = (op == OP_DIV);
      w_isDiv  = (op == OP_DIV) || (op == OP_DIVU);
      w_aExt   = w_mulSigned ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      w_bExt   = w_mulSigned ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      w_prod   = w_aExt * w_bExt;
      w_absA   = (w_isDivS && a[WIDTH-1]) ? -a : a;
      w_absB   = (w_isDivS && b[WIDTH-1]) ? -b : b;
   end

   // Restoring step: shift in the next dividend bit and try the subtraction.
   always_comb begin
      w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_divisor};
      w_fits   = ~w_trial[WIDTH];
      w_quoFix = r_qNeg ? -r_quo : r_quo;
      w_remFix = r_rNeg ? -r_rem : r_rem;
`ifdef MDU_MADD_EN
      if (r_accAdd) begin
         w_mulResult = {r_hi, r_lo} + r_prod;
      end else if (r_accSub) begin
         w_mulResult = {r_hi, r_lo} - r_prod;
      end else begin
         w_mulResult = r_prod;
      end
`else
      w_mulResult = r_prod;
`endif
   end

   // Control FSM and datapath registers; flush always wins over completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_divZero <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_aHold   <= '0;
         r_prod    <= '0;
         r_qNeg    <= 1'b0;
         r_rNeg    <= 1'b0;
         r_bZero   <= 1'b0;
`ifdef MDU_MADD_EN
         r_accAdd  <= 1'b0;
         r_accSub  <= 1'b0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_divZero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  r_cnt <= '0;
                  if (w_isMul) begin
                     r_prod  <= w_prod;
                     r_state <= S_MUL;
                     r_busy  <= 1'b1;
`ifdef MDU_MADD_EN
                     r_accAdd <= (op == OP_MADD) || (op == OP_MADDU);
                     r_accSub <= (op == OP_MSUB) || (op == OP_MSUBU);
`endif
                  end else if (w_isDiv) begin
                     r_rem     <= '0;
                     r_quo     <= w_absA;
                     r_divisor <= w_absB;
                     r_aHold   <= a;
                     r_bZero   <= (b == '0);
                     r_qNeg    <= w_isDivS && (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_rNeg    <= w_isDivS && a[WIDTH-1];
                     r_state   <= S_DIV;
                     r_busy    <= 1'b1;
                  end else if (op == OP_MTHI) begin
                     r_hi   <= a;
                     r_done <= 1'b1;
                  end else if (op == OP_MTLO) begin
                     r_lo   <= a;
                     r_done <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_cnt == MUL_LAST) begin
                  {r_hi, r_lo} <= w_mulResult;
                  r_done       <= 1'b1;
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_DIV: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_rem <= w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                  r_quo <= {r_quo[WIDTH-2:0], w_fits};
                  if (r_cnt == DIV_LAST) begin
                     r_state <= S_FIX;
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
            end
            S_FIX: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_bZero) begin
                     r_lo      <= '1;
                     r_hi      <= r_aHold;
                     r_divZero <= 1'b1;
                  end else begin
                     r_lo <= w_quoFix;
                     r_hi <= w_remFix;
                  end
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_divZero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule
